// File: rtl/shift_tx.sv
// shift_tx: parallel-in / serial-out transmitter, one bit per consumer strobe.
// Define PARITY_EN to append an even-parity bit after the data bits.
module shift_tx #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  msb_first,
  output logic                  in_ready,
  input  logic                  bit_en,
  output logic                  sout,
  output logic                  sout_valid,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sreg;
  logic [CW-1:0]         cnt;
  logic                  dir;
`ifdef PARITY_EN
  logic                  par;
`endif

  assign in_ready   = (state == IDLE) && !rst;
  assign sout_valid = (state != IDLE);
  assign busy       = (state != IDLE);

  always_comb begin
    sout = 1'b0;
    case (state)
      SHIFT: sout = dir ? sreg[DATA_WIDTH-1] : sreg[0];
`ifdef PARITY_EN
      PAR:   sout = par;
`endif
      default: sout = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
`ifdef PARITY_EN
      par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg  <= in_data;
            dir   <= msb_first;
            cnt   <= CW'(DATA_WIDTH - 1);
`ifdef PARITY_EN
            par   <= ^in_data;
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bit_en) begin
            // zero-fill from the far end so stale bits never re-emerge
            if (dir)
              sreg <= {sreg[DATA_WIDTH-2:0], 1'b0};
            else
              sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
            if (cnt != '0)
              cnt <= cnt - 1'b1;
            if (cnt == '0) begin
`ifdef PARITY_EN
              state <= PAR;
`else
              state <= IDLE;
              done  <= 1'b1;
`endif
            end
          end
        end
`ifdef PARITY_EN
        PAR: begin
          if (bit_en) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx.sv
// tb_shift_tx: vector table, corner sequences and random traffic for shift_tx.
// A bit-queue reference model predicts every output on every cycle.
module tb_shift_tx;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          msb_first;
  logic          in_ready;
  logic          bit_en;
  logic          sout;
  logic          sout_valid;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  bit q[$];
  bit done_m;

  typedef struct {
    logic [DW-1:0] data;
    bit            msb;
    bit            stall;
    logic [DW-1:0] exp_seq;
    bit            exp_par;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  shift_tx #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .msb_first (msb_first),
    .in_ready  (in_ready),
    .bit_en    (bit_en),
    .sout      (sout),
    .sout_valid(sout_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: a word becomes an ordered list of bits; each strobe pops one.
  task automatic model_edge();
    if (rst) begin
      q.delete();
      done_m = 1'b0;
    end else begin
      done_m = 1'b0;
      if (q.size() != 0) begin
        if (bit_en) begin
          void'(q.pop_front());
          if (q.size() == 0) done_m = 1'b1;
        end
      end else if (in_valid) begin
        for (int i = 0; i < DW; i++)
          q.push_back(msb_first ? in_data[DW-1-i] : in_data[i]);
`ifdef PARITY_EN
        q.push_back(^in_data);
`endif
      end
    end
  endtask

  task automatic compare_all();
    bit v;
    v = (q.size() != 0);
    chk("in_ready", 32'(in_ready), 32'(!v && !rst));
    chk("sout_valid", 32'(sout_valid), 32'(v));
    chk("sout", 32'(sout), 32'(v ? q[0] : 1'b0));
    chk("busy", 32'(busy), 32'(v));
    chk("done", 32'(done), 32'(done_m));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!in_ready && k < 100) begin
      step();
      k++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [DW-1:0] d, input bit m);
    wait_ready();
    in_valid  = 1'b1;
    in_data   = d;
    msb_first = m;
    bit_en    = 1'b0;
    step();
    in_valid  = 1'b0;
    in_data   = DW'($urandom);
    msb_first = 1'($urandom);
  endtask

  task automatic run_vec(input string name, input vec_t t);
    logic [DW:0] got;
    logic [DW:0] exp;
    int n, lat, exp_lat, exp_n;
    accept(t.data, t.msb);
    got = '0;
    n   = 0;
    lat = -1;
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        lat = c;
        break;
      end
      bit_en = t.stall ? 1'(c % 2) : 1'b1;
      if (sout_valid && bit_en) begin
        got = {got[DW-1:0], sout};
        n++;
      end
      step();
    end
    bit_en = 1'b0;
`ifdef PARITY_EN
    exp     = {t.exp_seq, t.exp_par};
    exp_n   = DW + 1;
    exp_lat = t.stall ? 2 * (DW + 1) : DW + 1;
`else
    exp     = {1'b0, t.exp_seq};
    exp_n   = DW;
    exp_lat = t.stall ? 2 * DW : DW;
`endif
    chk({name, "_bits"}, 32'(got), 32'(exp));
    chk({name, "_count"}, 32'(n), 32'(exp_n));
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t ab;
    vecs[0] = '{16'hA5C3, 1'b1, 1'b0, 16'hA5C3, 1'b0};
    vecs[1] = '{16'hA5C3, 1'b0, 1'b0, 16'hC3A5, 1'b0};
    vecs[2] = '{16'hA5C3, 1'b1, 1'b1, 16'hA5C3, 1'b0};
    vecs[3] = '{16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1};
    vecs[4] = '{16'h0003, 1'b1, 1'b0, 16'h0003, 1'b0};
    vecs[5] = '{16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'h1234;
    msb_first = 1'b1;
    bit_en    = 1'b0;
    step();
    step();
    chk("reset_ready", 32'(in_ready), 32'd0);
    chk("reset_valid", 32'(sout_valid), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk("release_ready", 32'(in_ready), 32'd1);
    chk("release_valid", 32'(sout_valid), 32'd0);
    chk("release_done", 32'(done), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);

    foreach (vecs[i])
      run_vec($sformatf("vec%0d", i), vecs[i]);

    // Abort after five bits, then a fresh word must start cleanly.
    accept(16'hA5C3, 1'b1);
    bit_en = 1'b1;
    repeat (5) step();
    rst    = 1'b1;
    bit_en = 1'b0;
    step();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (3) begin
      step();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    ab = '{16'h8001, 1'b1, 1'b0, 16'h8001, 1'b0};
    run_vec("after_abort", ab);

    // Random traffic, including accepts in the done cycle and rare resets.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom % 2);
      in_data   = DW'($urandom);
      msb_first = 1'($urandom);
      bit_en    = ($urandom % 4) != 0;
      rst       = ($urandom % 300) == 0;
      step();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    bit_en   = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
